// File: rtl/scoreboard_pkg.sv
// Shared sizes and types for the per-thread register-hazard scoreboard.
package scoreboard_pkg;
  localparam int NUM_TIDS  = 256;
  localparam int NUM_REGS  = 34;
  localparam int TID_W     = 8;
  localparam int REG_IDX_W = 7;

  typedef logic [TID_W-1:0]     tid_t;
  typedef logic [NUM_REGS-1:0]  reg_map_t;
  typedef logic [NUM_TIDS-1:0]  tid_bitmap_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/scoreboard_row.sv
// Pending-write-back vector for one thread: bulk set from a register map,
// single-bit clear by index, with set taking priority on the same bit.
module scoreboard_row
  import scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [NUM_REGS-1:0] set_map,
  input  logic                clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  output logic [NUM_REGS-1:0] pending
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] clr_mask;

  // Indices beyond the register file match no bit, so they release nothing.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (clr_en && (clr_idx == REG_IDX_W'(i))) begin
        clr_mask[i] = 1'b1;
      end
    end
  end

  // Clear first, then set: a new reservation outranks a stale write-back.
  always_comb begin
    pending_d = pending_q & ~clr_mask;
    if (set_en) begin
      pending_d = pending_d | set_map;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/scoreboard.sv
// Per-thread RAW hazard scoreboard: one check, one reservation and one
// bitmap release per cycle. Optional macro SCOREBOARD_WB_BYPASS_EN.
module scoreboard
  import scoreboard_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REGS-1:0]  input_regs_map,
  input  logic [TID_W-1:0]     rd_tid,
  input  logic                 rd_valid,
  input  logic [TID_W-1:0]     rsv_tid,
  input  logic                 rsv_valid,
  input  logic [NUM_TIDS-1:0]  wb_tid_bitmap,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] ld_dest_reg,
  output logic                 collision
);

  logic [NUM_REGS-1:0] pending_rows [NUM_TIDS];
  logic [NUM_REGS-1:0] rd_row;
  logic [NUM_REGS-1:0] bypass_mask;

  generate
    for (genvar gi = 0; gi < NUM_TIDS; gi++) begin : g_row
      logic set_en;
      logic clr_en;

      assign set_en = rsv_valid && (rsv_tid == TID_W'(gi));
      assign clr_en = wb_valid && wb_tid_bitmap[gi];

      scoreboard_row u_row (
        .clk     (clk),
        .rst     (rst),
        .set_en  (set_en),
        .set_map (input_regs_map),
        .clr_en  (clr_en),
        .clr_idx (ld_dest_reg),
        .pending (pending_rows[gi])
      );
    end
  endgenerate

  assign rd_row = pending_rows[rd_tid];

`ifdef SCOREBOARD_WB_BYPASS_EN
  // Hide the bit that this cycle's write-back is about to clear.
  always_comb begin
    bypass_mask = '1;
    if (wb_valid && wb_tid_bitmap[rd_tid]) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ld_dest_reg == REG_IDX_W'(i)) begin
          bypass_mask[i] = 1'b0;
        end
      end
    end
  end
`else
  assign bypass_mask = '1;
`endif

  assign collision = rd_valid && (|(rd_row & input_regs_map & bypass_mask));

endmodule

// File: tb/tb_scoreboard.sv
// Scoreboard-style bench: stimulus pushes expected collision values, a
// negedge monitor pops and compares. Honours SCOREBOARD_WB_BYPASS_EN.
module tb_scoreboard;
  import scoreboard_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REGS-1:0]  input_regs_map;
  logic [TID_W-1:0]     rd_tid;
  logic                 rd_valid;
  logic [TID_W-1:0]     rsv_tid;
  logic                 rsv_valid;
  logic [NUM_TIDS-1:0]  wb_tid_bitmap;
  logic                 wb_valid;
  logic [REG_IDX_W-1:0] ld_dest_reg;
  logic                 collision;

  scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .input_regs_map (input_regs_map),
    .rd_tid         (rd_tid),
    .rd_valid       (rd_valid),
    .rsv_tid        (rsv_tid),
    .rsv_valid      (rsv_valid),
    .wb_tid_bitmap  (wb_tid_bitmap),
    .wb_valid       (wb_valid),
    .ld_dest_reg    (ld_dest_reg),
    .collision      (collision)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit    exp;
    string name;
    int    tid;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: pending[tid][reg] as independent booleans.
  bit pend [NUM_TIDS][NUM_REGS];

  function automatic void model_clear();
    for (int t = 0; t < NUM_TIDS; t++)
      for (int r = 0; r < NUM_REGS; r++)
        pend[t][r] = 1'b0;
  endfunction

  function automatic bit model_hazard(int t, logic [NUM_REGS-1:0] m, bit wv,
                                      logic [NUM_TIDS-1:0] bm, int dest);
    bit h = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      bit hidden = 1'b0;
`ifdef SCOREBOARD_WB_BYPASS_EN
      hidden = wv && bm[t] && (dest == r);
`endif
      if (m[r] && pend[t][r] && !hidden) h = 1'b1;
    end
    return h;
  endfunction

  // One cycle of stimulus: drive just after the edge, record the expected
  // read result from pre-edge state, then apply release followed by reserve.
  task automatic step(input bit rv, input int rt, input logic [NUM_REGS-1:0] m,
                      input bit sv, input int st, input bit wv,
                      input logic [NUM_TIDS-1:0] bm, input int dest,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rd_valid       = rv;
    rd_tid         = TID_W'(rt);
    input_regs_map = m;
    rsv_valid      = sv;
    rsv_tid        = TID_W'(st);
    wb_valid       = wv;
    wb_tid_bitmap  = bm;
    ld_dest_reg    = REG_IDX_W'(dest);
    if (rv) begin
      e.exp  = model_hazard(rt, m, wv, bm, dest);
      e.name = nm;
      e.tid  = rt;
      exp_q.push_back(e);
    end
    if (wv && dest < NUM_REGS)
      for (int t = 0; t < NUM_TIDS; t++)
        if (bm[t]) pend[t][dest] = 1'b0;
    if (sv)
      for (int r = 0; r < NUM_REGS; r++)
        if (m[r]) pend[st][r] = 1'b1;
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, 0, '0, 0, "idle");
  endtask

  function automatic logic [NUM_TIDS-1:0] one_tid(int t);
    logic [NUM_TIDS-1:0] b = '0;
    b[t] = 1'b1;
    return b;
  endfunction

  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      exp_t e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_read: tid=%0d collision=%0b with no expectation queued",
                 rd_tid, collision);
      end else begin
        e = exp_q.pop_front();
        if (collision !== e.exp) begin
          bad++;
          $display("FAIL %s: tid=%0d collision got=%0b expected=%0b",
                   e.name, e.tid, collision, e.exp);
        end
      end
    end
  end

  function automatic int rand_tid();
    return ($urandom_range(3, 0) != 0) ? int'($urandom_range(15, 0))
                                       : int'($urandom_range(255, 0));
  endfunction

  initial begin
    logic [NUM_TIDS-1:0] bm;
    logic [NUM_REGS-1:0] m;
    int dest;

    rst = 1'b1;
    rd_valid = 0; rsv_valid = 0; wb_valid = 0;
    rd_tid = '0; rsv_tid = '0; input_regs_map = '0;
    wb_tid_bitmap = '0; ld_dest_reg = '0;
    model_clear();
    #1;
    total++;
    if (collision !== 1'b0) begin
      bad++;
      $display("FAIL reset_collision: got=%0b expected=0", collision);
    end
    #12 rst = 1'b0;

    // Empty scoreboard never collides.
    for (int t = 0; t < NUM_TIDS; t++)
      step(1, t, '1, 0, 0, 0, '0, 0, "after_reset");

    step(0, 0, 34'hF, 1, 8, 0, '0, 0, "rsv8");
    step(1, 8, 34'h4, 0, 0, 0, '0, 0, "t2_reg2");
    step(1, 8, 34'h10, 0, 0, 0, '0, 0, "t2_reg4");
    step(1, 9, 34'hF, 0, 0, 0, '0, 0, "t2_tid9");

    step(0, 0, '0, 0, 0, 1, one_tid(8), 2, "rel8_2");
    step(1, 8, 34'h4, 0, 0, 0, '0, 0, "t3_reg2");
    step(1, 8, 34'h8, 0, 0, 0, '0, 0, "t3_reg3");
    step(0, 0, '0, 0, 0, 1, one_tid(8), 100, "rel8_100");
    step(1, 8, 34'h8, 0, 0, 0, '0, 0, "t3_oob_reg3");
    step(1, 8, 34'h3, 0, 0, 0, '0, 0, "t3_oob_reg01");

    for (int t = 0; t < 32; t++)
      step(0, 0, 34'h20, 1, t, 0, '0, 0, "rsv_r5");
    step(1, 5, 34'h20, 0, 0, 0, '0, 0, "t4_pre");
    bm = '0; bm[31:0] = 32'hFFFF_FFFF;
    step(0, 0, '0, 0, 0, 1, bm, 5, "rel32_5");
    for (int t = 0; t < 32; t++)
      step(1, t, 34'h20, 0, 0, 0, '0, 0, "t4_released");

    step(1, 51, 34'h8, 1, 51, 1, one_tid(51), 3, "t5_same_cycle");
    step(1, 51, 34'h8, 0, 0, 0, '0, 0, "t5_set_wins");

    step(0, 0, 34'h2, 1, 3, 0, '0, 0, "rsv3");
    step(1, 3, 34'h2, 0, 0, 0, '0, 0, "t6_before_rst");
    #5;
    rst = 1'b1;
    #1;
    total++;
    if (collision !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: collision got=%0b expected=0", collision);
    end
    model_clear();
    rd_valid = 1'b0;
    #1 rst = 1'b0;
    step(1, 3, 34'h2, 0, 0, 0, '0, 0, "t6_after_rst");
    step(0, 0, 34'h2, 1, 3, 0, '0, 0, "rsv3b");
    step(1, 3, 34'h2, 0, 0, 1, one_tid(3), 1, "t6_bypass");
    step(1, 3, 34'h2, 0, 0, 0, '0, 0, "t6_released");

    // Random mix of concurrent reads, reservations and releases.
    for (int n = 0; n < 3000; n++) begin
      bm = '0;
      for (int k = 0; k < 3; k++) bm[$urandom_range(15, 0)] = 1'b1;
      if ($urandom_range(7, 0) == 0)
        for (int w = 0; w < NUM_TIDS / 32; w++) bm[w*32 +: 32] = $urandom();
      m = {$urandom_range(3, 0), $urandom()} & {$urandom_range(3, 0), $urandom()};
      dest = ($urandom_range(9, 0) == 0) ? int'($urandom_range(127, 34))
                                         : int'($urandom_range(33, 0));
      step($urandom_range(1, 0), rand_tid(), m, $urandom_range(1, 0), rand_tid(),
           $urandom_range(1, 0), bm, dest, "random");
    end
    idle();
    idle();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: leftover=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
